rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 4: data width per channel, legal range 1..64.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port in_data  input  N*W: channel i occupies bits [i*W+W-1 : i*W].
REQ-006 Port in_valid  input  N: per-channel valid.
REQ-007 Port in_ready  output  N: per-channel ready.
REQ-008 Port out_data  output  W: registered selected data.
REQ-009 Port out_valid  output  1: out_data holds a beat.
REQ-010 Port out_ready  input  1: downstream accepts the beat.
REQ-011 Port out_sel  output  clog2(N): source channel of the current out_data.

Function
REQ-012 Transfers: input beat on in_valid[i] & in_ready[i] at a rising edge; output beat on out_valid & out_ready at a rising edge.
REQ-013 load_en = !out_valid | out_ready; the output register loads only when load_en is 1 and at least one in_valid bit is 1.
REQ-014 Arbitration is round-robin: search starts at channel (ptr+1) mod N and the first valid channel wins; ptr = index of last granted channel.
REQ-015 ptr updates to the granted index on every input transfer only; it is unchanged on idle cycles.
REQ-016 in_ready[i] = load_en & (grant == i); at most one in_ready bit is 1 per cycle; in_ready is 0 for all channels when no in_valid is set.
REQ-017 On an input transfer: out_data <= winning channel's data, out_sel <= its index, out_valid <= 1, all in the same edge.
REQ-018 Latency: an accepted beat appears on out_data exactly 1 cycle after acceptance.
REQ-019 Throughput: with out_ready held 1, one beat per cycle is sustained, including back-to-back beats from different channels.
REQ-020 Output drained with no valid input: out_valid <= 0; out_data and out_sel hold their last values.
REQ-021 Stall: out_valid=1 and out_ready=0: out_data, out_sel and out_valid hold; all in_ready are 0.
REQ-022 Wrap-around: grant after channel N-1 searches from channel 0.
REQ-023 Single requester: the same channel is granted on consecutive cycles without gaps.
REQ-024 in_valid dropped by a non-granted channel has no effect on ptr or the output.

Reset
REQ-025 rst_n low asynchronously forces out_valid=0, out_data=0, out_sel=0, ptr=N-1 (channel 0 has first priority).
REQ-026 Reset mid-transfer discards the held beat; in_ready is 0 while rst_n is low.
REQ-027 First rising edge after rst_n rises is a normal arbitration cycle.

Configuration
REQ-028 Macro RR_MUX_PKT_LOCK_EN: when defined, ports in_last (input, N) and out_last (output, 1, registered with out_data, reset 0) are added.
REQ-029 With RR_MUX_PKT_LOCK_EN: after granting channel i, grant locks on i until a beat with in_last[i]=1 transfers; other channels get no in_ready meanwhile, even if i deasserts in_valid.
REQ-030 Without RR_MUX_PKT_LOCK_EN: no last ports; arbitration is re-run on every beat per REQ-014.

Verification (N=4, W=4)
REQ-031 Reset, then in_valid=4'b0001, in_data ch0=4'b1111, out_ready=1 -> next cycle out_data=4'b1111, out_sel=0, out_valid=1.
REQ-032 All valid, data ch0..3 = 4'b0000,4'b0001,4'b0010,4'b0011, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data matches.
REQ-033 out_valid=1 holding 4'b1110, out_ready=0 for 3 cycles -> out_data stable, in_ready=4'b0000; out_ready=1 -> next beat loads same cycle.
REQ-034 in_valid=4'b1000 then 4'b1001 -> grants 3 then 0 (wrap-around).
REQ-035 rst_n low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately; first grant after release is channel 0.
REQ-036 With RR_MUX_PKT_LOCK_EN: ch1 sends 3 beats, in_last on third, ch2 valid throughout -> ch2 granted only after ch1's last beat; out_last=1 on that beat.

Source files
------------

// File: rtl/rr_mux.sv
// rtl/rr_mux.sv - N-channel round-robin stream mux with registered output
// Optional packet lock on in_last when RR_MUX_PKT_LOCK_EN is defined.
module rr_mux #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [N-1:0]         in_last,
    output logic                 out_last,
`endif
    output logic [$clog2(N)-1:0] out_sel
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr;
    logic [SW-1:0] grant;
    logic [SW-1:0] cand;
    logic          found;
    logic          load_en;
    logic          xfer;
`ifdef RR_MUX_PKT_LOCK_EN
    logic          locked;
`endif

    // Search starts one past the last granted channel, so ptr=N-1 favours channel 0.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SW'((int'(ptr) + k) % N);
            if (!found && in_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
`ifdef RR_MUX_PKT_LOCK_EN
        // While a packet is open only its owner (held in ptr) may transfer.
        if (locked) begin
            grant = ptr;
            found = in_valid[ptr];
        end
`endif
    end

    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && found && rst_n;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SW'(N - 1);
`ifdef RR_MUX_PKT_LOCK_EN
            locked    <= 1'b0;
            out_last  <= 1'b0;
`endif
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant*W +: W];
                out_sel   <= grant;
                ptr       <= grant;
`ifdef RR_MUX_PKT_LOCK_EN
                locked    <= !in_last[grant];
                out_last  <= in_last[grant];
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// tb/tb_rr_mux.sv - table-driven scoreboard bench for rr_mux (N=4, W=4)
module tb_rr_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;
`ifdef RR_MUX_PKT_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    rr_mux #(.N(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef RR_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] d;
        logic        ordy;
        logic [3:0]  exp_rdy;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
    } beat_t;

    vec_t  tbl[20];
    beat_t q[$];
    int    pass_cnt = 0;
    int    total    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] v, input logic [15:0] d, input logic ordy,
                        input logic [3:0] er, input string nm);
        beat_t b;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk({nm, " in_ready"}, 32'(in_ready), 32'(er));
        chk({nm, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        if (out_valid && out_ready && q.size() != 0) begin
            b = q.pop_front();
            chk({nm, " out_sel"}, 32'(out_sel), 32'(b.sel));
            chk({nm, " out_data"}, 32'(out_data), 32'(b.data));
        end
        for (int i = 0; i < 4; i++) begin
            if (er[i]) begin
                b.sel  = 2'(i);
                b.data = d[i*4 +: 4];
                q.push_back(b);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 16'h3210, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 16'h3210, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 16'h3210, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 16'h3210, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 16'h3210, 1'b1, 4'b0001};
        tbl[5]  = '{4'b0000, 16'h3210, 1'b1, 4'b0000};
        tbl[6]  = '{4'b0001, 16'h000F, 1'b1, 4'b0001};
        tbl[7]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000};
        tbl[8]  = '{4'b1000, 16'hE000, 1'b1, 4'b1000};
        tbl[9]  = '{4'b1001, 16'h2001, 1'b1, 4'b0001};
        tbl[10] = '{4'b1001, 16'h2001, 1'b1, 4'b1000};
        tbl[11] = '{4'b0100, 16'h0E00, 1'b1, 4'b0100};
        tbl[12] = '{4'b0010, 16'h0050, 1'b0, 4'b0000};
        tbl[13] = '{4'b0010, 16'h0050, 1'b0, 4'b0000};
        tbl[14] = '{4'b0010, 16'h0050, 1'b0, 4'b0000};
        tbl[15] = '{4'b0010, 16'h0050, 1'b1, 4'b0010};
        tbl[16] = '{4'b0000, 16'h0000, 1'b1, 4'b0000};
        tbl[17] = '{4'b0100, 16'h0700, 1'b1, 4'b0100};
        tbl[18] = '{4'b0100, 16'h0800, 1'b1, 4'b0100};
        tbl[19] = '{4'b0000, 16'h0000, 1'b1, 4'b0000};

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 16'hABCD;
        out_ready = 1'b1;
`ifdef RR_MUX_PKT_LOCK_EN
        in_last   = 4'b1111;
`endif
        #1;
        chk("reset in_ready", 32'(in_ready), 32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset out_sel", 32'(out_sel), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].exp_rdy, $sformatf("row%0d", i));
        end

        // Asynchronous reset with a beat held in the output register.
        step(4'b1111, 16'h9876, 1'b1, 4'b1000, "pre_rst0");
        step(4'b1111, 16'h9876, 1'b1, 4'b0001, "pre_rst1");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst out_data", 32'(out_data), 32'h0);
        chk("midrst out_sel", 32'(out_sel), 32'h0);
        chk("midrst in_ready", 32'(in_ready), 32'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 16'h9876, 1'b1, 4'b0001, "post_rst0");
        step(4'b0000, 16'h0000, 1'b1, 4'b0000, "post_rst1");
        step(4'b0000, 16'h0000, 1'b1, 4'b0000, "post_rst2");

`ifdef RR_MUX_PKT_LOCK_EN
        in_last = 4'b0000;
        step(4'b0010, 16'h0910, 1'b1, 4'b0010, "lock0");
        step(4'b0110, 16'h0920, 1'b1, 4'b0010, "lock1");
        in_last = 4'b0010;
        step(4'b0110, 16'h0930, 1'b1, 4'b0010, "lock2");
        chk("lock out_last", 32'(out_last), 32'h1);
        in_last = 4'b1111;
        step(4'b0100, 16'h0940, 1'b1, 4'b0100, "lock3");
        step(4'b0000, 16'h0000, 1'b1, 4'b0000, "lock4");
`endif

        chk("final queue empty", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
